// File: rtl/advtim_pkg.sv
// Shared constants and types for the advanced-timer time-base.
// Latency: n/a (definitions only); backpressure: n/a.
package advtim_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int RCR_W_DEF = 8;
  localparam int NCH_DEF   = 6;

  localparam logic [1:0] CMS_EDGE = 2'b00;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    SRC_CNT = 1'b0,
    SRC_UG  = 1'b1
  } uev_src_e;

endpackage

// File: rtl/advtim_prescaler.sv
// Prescaler: emits a tick every psc_shadow+1 enabled cycles; shadow reloads at update events.
// Latency: tick is combinational from the registered count; backpressure: none, en simply holds the count.
module advtim_prescaler
  import advtim_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             pe_gen_clk,
  input  logic             pe_gen_rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] psc,
  output logic             tick
);

  logic [CNT_W-1:0] psc_cnt;
  logic [CNT_W-1:0] psc_shadow;

  assign tick = en && (psc_cnt == psc_shadow);

  always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
    if (!pe_gen_rstn) begin
      psc_cnt    <= '0;
      psc_shadow <= '0;
    end else begin
      if (clr) begin
        psc_cnt <= '0;
      end else if (en) begin
        psc_cnt <= tick ? '0 : psc_cnt + CNT_W'(1);
      end
      if (load) begin
        psc_shadow <= psc;
      end
    end
  end

endmodule

// File: rtl/advtim_timebase_ctrl.sv
// Timer time-base: prescaled up/down/center counter, repetition-qualified UEV, ARR/CC preload commit.
// Latency: all outputs registered, one cycle after the causing tick/UG; backpressure: none.
module advtim_timebase_ctrl
  import advtim_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RCR_W = RCR_W_DEF,
  parameter int NCH   = NCH_DEF
) (
  input  logic                 pe_gen_clk,
  input  logic                 pe_gen_rstn,
  input  logic                 r_cen,
  input  logic                 r_dir,
  input  logic [1:0]           r_cms,
  input  logic                 r_opm,
  input  logic                 r_arpe,
  input  logic                 r_ocpe,
  input  logic                 r_udis,
  input  logic                 r_urs,
  input  logic                 r_ug,
  input  logic [CNT_W-1:0]     r_psc,
  input  logic [CNT_W-1:0]     r_arr,
  input  logic [RCR_W-1:0]     r_rcr,
  input  logic [NCH*CNT_W-1:0] r_cc_pre,
  output logic [CNT_W-1:0]     arr_cnt,
  output logic                 dir,
  output logic                 timing_enable,
  output logic [NCH*CNT_W-1:0] cc_act,
  output logic                 uev,
  output logic                 uif_set,
  output logic                 cen_clr
);

  logic [CNT_W-1:0]     arr_shadow;
  logic [CNT_W-1:0]     arr_act;
  logic [NCH*CNT_W-1:0] cc_shadow;
  logic [RCR_W-1:0]     rep_cnt;
  logic                 stop_lock;
  logic                 tick;
  logic                 center;
  logic                 evt;
  logic                 cnt_uev;
  logic                 ug_uev;
  logic                 uev_next;
  logic                 uif_next;
  logic                 opm_stop;
  logic [CNT_W-1:0]     cnt_next;
  logic                 dir_next;
  uev_src_e             uev_src;

  assign center  = (r_cms != CMS_EDGE);
  assign arr_act = r_arpe ? arr_shadow : r_arr;

  advtim_prescaler #(.CNT_W(CNT_W)) u_psc (
    .pe_gen_clk  (pe_gen_clk),
    .pe_gen_rstn (pe_gen_rstn),
    .en          (timing_enable),
    .clr         (r_ug),
    .load        (uev_next),
    .psc         (r_psc),
    .tick        (tick)
  );

  // UG has priority over any tick; evt flags an over/underflow on this tick.
  always_comb begin
    cnt_next = arr_cnt;
    dir_next = dir;
    evt      = 1'b0;
    if (r_ug) begin
      cnt_next = (!center && r_dir == DIR_DOWN) ? arr_act : '0;
      dir_next = center ? DIR_UP : r_dir;
    end else begin
      if (!center) begin
        dir_next = r_dir;
      end
      if (tick) begin
        if (arr_act == '0) begin
          cnt_next = '0;
        end else if (!center) begin
          if (r_dir == DIR_UP) begin
            if (arr_cnt >= arr_act) begin
              cnt_next = '0;
              evt      = 1'b1;
            end else begin
              cnt_next = arr_cnt + CNT_W'(1);
            end
          end else if (arr_cnt == '0) begin
            cnt_next = arr_act;
            evt      = 1'b1;
          end else begin
            cnt_next = arr_cnt - CNT_W'(1);
          end
        end else if (dir == DIR_UP) begin
          if (arr_cnt >= arr_act) begin
            cnt_next = arr_act - CNT_W'(1);
            dir_next = DIR_DOWN;
            evt      = 1'b1;
          end else begin
            cnt_next = arr_cnt + CNT_W'(1);
          end
        end else if (arr_cnt == '0) begin
          cnt_next = CNT_W'(1);
          dir_next = DIR_UP;
          evt      = 1'b1;
        end else begin
          cnt_next = arr_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign uev_src  = r_ug ? SRC_UG : SRC_CNT;
  assign cnt_uev  = evt && !r_udis && (rep_cnt == '0);
  assign ug_uev   = r_ug && !r_udis;
  assign uev_next = cnt_uev || ug_uev;
  assign uif_next = uev_next && !(uev_src == SRC_UG && r_urs);
  assign opm_stop = r_opm && cnt_uev;

  always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
    if (!pe_gen_rstn) begin
      arr_cnt       <= '0;
      dir           <= DIR_UP;
      timing_enable <= 1'b0;
      stop_lock     <= 1'b0;
      cc_act        <= '0;
      uev           <= 1'b0;
      uif_set       <= 1'b0;
      cen_clr       <= 1'b0;
      rep_cnt       <= '0;
      arr_shadow    <= '0;
      cc_shadow     <= '0;
    end else begin
      arr_cnt       <= cnt_next;
      dir           <= dir_next;
      timing_enable <= r_cen && !stop_lock && !opm_stop;
      uev           <= uev_next;
      uif_set       <= uif_next;
      cen_clr       <= opm_stop;
      cc_act        <= r_ocpe ? cc_shadow : r_cc_pre;
      // One-pulse stop sticks until software drops CEN.
      if (opm_stop) begin
        stop_lock <= 1'b1;
      end else if (!r_cen) begin
        stop_lock <= 1'b0;
      end
      if (!r_udis) begin
        if (r_ug || (evt && rep_cnt == '0)) begin
          rep_cnt <= r_rcr;
        end else if (evt) begin
          rep_cnt <= rep_cnt - RCR_W'(1);
        end
      end
      if (uev_next) begin
        arr_shadow <= r_arr;
        cc_shadow  <= r_cc_pre;
      end
    end
  end

endmodule

// File: tb/tb_advtim_timebase_ctrl.sv
// Self-checking bench for advtim_timebase_ctrl: directed scenarios plus randomized time-base trials
// checked against closed-form period arithmetic.
module tb_advtim_timebase_ctrl;
  import advtim_pkg::*;

  localparam int CNT_W = 16;
  localparam int RCR_W = 8;
  localparam int NCH   = 6;
  localparam int W     = NCH * CNT_W;
  localparam int NCYC  = 40;

  typedef logic [W-1:0] wide_t;

  logic             pe_gen_clk;
  logic             pe_gen_rstn;
  logic             r_cen, r_dir, r_opm, r_arpe, r_ocpe, r_udis, r_urs, r_ug;
  logic [1:0]       r_cms;
  logic [CNT_W-1:0] r_psc, r_arr;
  logic [RCR_W-1:0] r_rcr;
  logic [W-1:0]     r_cc_pre;
  logic [CNT_W-1:0] arr_cnt;
  logic             dir, timing_enable, uev, uif_set, cen_clr;
  logic [W-1:0]     cc_act;

  int n_cmp  = 0;
  int n_fail = 0;

  advtim_timebase_ctrl #(.CNT_W(CNT_W), .RCR_W(RCR_W), .NCH(NCH)) dut (
    .pe_gen_clk    (pe_gen_clk),
    .pe_gen_rstn   (pe_gen_rstn),
    .r_cen         (r_cen),
    .r_dir         (r_dir),
    .r_cms         (r_cms),
    .r_opm         (r_opm),
    .r_arpe        (r_arpe),
    .r_ocpe        (r_ocpe),
    .r_udis        (r_udis),
    .r_urs         (r_urs),
    .r_ug          (r_ug),
    .r_psc         (r_psc),
    .r_arr         (r_arr),
    .r_rcr         (r_rcr),
    .r_cc_pre      (r_cc_pre),
    .arr_cnt       (arr_cnt),
    .dir           (dir),
    .timing_enable (timing_enable),
    .cc_act        (cc_act),
    .uev           (uev),
    .uif_set       (uif_set),
    .cen_clr       (cen_clr)
  );

  initial pe_gen_clk = 1'b0;
  always #5 pe_gen_clk = ~pe_gen_clk;

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pe_gen_clk);
    #1;
  endtask

  // mode: 0 edge up, 1 edge down, 2 center. T = ticks since the UG reset.
  function automatic int ref_cnt(int mode, int a, int T);
    int q;
    if (mode == 0) return T % (a + 1);
    if (mode == 1) return a - (T % (a + 1));
    q = T % (2 * a);
    return (q <= a) ? q : 2 * a - q;
  endfunction

  function automatic int ref_dir(int mode, int a, int T);
    int q;
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    if (T == 0) return 0;
    q = T % (2 * a);
    return (q == 0 || q > a) ? 1 : 0;
  endfunction

  // Does tick number k (1-based) cross an over/underflow boundary?
  function automatic bit ref_evt(int mode, int a, int k);
    if (mode != 2) return (k % (a + 1)) == 0;
    return (k > 1) && ((k % (2 * a)) == ((a + 1) % (2 * a)) || (k % (2 * a)) == 1);
  endfunction

  task automatic run_trial(input int mode, input int p, input int a, input int r);
    int T, ev, exp_uev;
    r_cen = 1'b0;
    step();
    step();
    r_cms    = (mode == 2) ? 2'b01 : 2'b00;
    r_dir    = (mode == 1) ? 1'b1 : ((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    r_psc    = CNT_W'(p);
    r_arr    = CNT_W'(a);
    r_rcr    = RCR_W'(r);
    r_arpe   = 1'b0;
    r_ocpe   = 1'b0;
    r_udis   = 1'b0;
    r_urs    = 1'b0;
    r_opm    = 1'b0;
    r_cc_pre = {$urandom, $urandom, $urandom};
    r_ug     = 1'b1;
    step();
    chk("ug_uev", wide_t'(uev), wide_t'(1));
    r_ug  = 1'b0;
    r_cen = 1'b1;
    step();
    chk("cc_direct", cc_act, r_cc_pre);
    ev = 0;
    for (int m = 0; m < NCYC; m++) begin
      T       = m / (p + 1);
      exp_uev = 0;
      if (m > 0 && (m % (p + 1)) == 0 && ref_evt(mode, a, T)) begin
        ev++;
        exp_uev = ((ev % (r + 1)) == 0) ? 1 : 0;
      end
      chk("cnt", wide_t'(arr_cnt), wide_t'(ref_cnt(mode, a, T)));
      chk("dir", wide_t'(dir), wide_t'(ref_dir(mode, a, T)));
      chk("uev", wide_t'(uev), wide_t'(exp_uev));
      chk("uif", wide_t'(uif_set), wide_t'(exp_uev));
      step();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt"}, wide_t'(arr_cnt), '0);
    chk({tag, "_dir"}, wide_t'(dir), '0);
    chk({tag, "_te"}, wide_t'(timing_enable), '0);
    chk({tag, "_cc"}, cc_act, '0);
    chk({tag, "_uev"}, wide_t'(uev), '0);
    chk({tag, "_uif"}, wide_t'(uif_set), '0);
    chk({tag, "_cenclr"}, wide_t'(cen_clr), '0);
  endtask

  initial begin
    pe_gen_rstn = 1'b0;
    r_cen = 0; r_dir = 0; r_cms = 0; r_opm = 0; r_arpe = 0; r_ocpe = 0;
    r_udis = 0; r_urs = 0; r_ug = 0; r_psc = 0; r_arr = 0; r_rcr = 0; r_cc_pre = '0;
    #12;
    chk_all_zero("rst");
    pe_gen_rstn = 1'b1;
    step();

    // Directed period scenarios, then randomized ones.
    run_trial(0, 0, 4, 0);
    run_trial(2, 1, 3, 1);
    for (int t = 0; t < 10; t++) begin
      run_trial(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
    end

    // ARR/CC preload: new values take effect only after the next UEV.
    r_cen = 1'b0;
    step();
    step();
    r_cms = 2'b00; r_dir = 1'b0; r_psc = '0; r_arr = 16'd9; r_rcr = '0;
    r_arpe = 1'b1; r_ocpe = 1'b1; r_cc_pre = wide_t'(3); r_ug = 1'b1;
    step();
    r_ug  = 1'b0;
    r_cen = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    r_arr    = 16'd5;
    r_cc_pre = wide_t'(7);
    step();
    chk("pre_cc_hold", cc_act, wide_t'(3));
    for (int i = 0; i < 5; i++) step();
    chk("pre_reach9", wide_t'(arr_cnt), wide_t'(9));
    step();
    chk("pre_wrap_cnt", wide_t'(arr_cnt), wide_t'(0));
    chk("pre_wrap_uev", wide_t'(uev), wide_t'(1));
    step();
    chk("pre_cc_new", cc_act, wide_t'(7));
    for (int i = 0; i < 4; i++) step();
    chk("pre_cnt5", wide_t'(arr_cnt), wide_t'(5));
    chk("pre_no_uev", wide_t'(uev), wide_t'(0));
    step();
    chk("pre_period6", wide_t'(uev), wide_t'(1));

    // URS: UG-sourced update sets UIF only when urs=0.
    r_arpe = 1'b0;
    r_arr  = 16'd9;
    for (int i = 0; i < 30 && arr_cnt != 16'd6; i++) step();
    chk("urs1_at6", wide_t'(arr_cnt), wide_t'(6));
    r_urs = 1'b1;
    r_ug  = 1'b1;
    step();
    r_ug = 1'b0;
    chk("urs1_cnt", wide_t'(arr_cnt), wide_t'(0));
    chk("urs1_uev", wide_t'(uev), wide_t'(1));
    chk("urs1_uif", wide_t'(uif_set), wide_t'(0));
    r_urs = 1'b0;
    for (int i = 0; i < 30 && arr_cnt != 16'd6; i++) step();
    chk("urs0_at6", wide_t'(arr_cnt), wide_t'(6));
    r_ug = 1'b1;
    step();
    r_ug = 1'b0;
    chk("urs0_cnt", wide_t'(arr_cnt), wide_t'(0));
    chk("urs0_uev", wide_t'(uev), wide_t'(1));
    chk("urs0_uif", wide_t'(uif_set), wide_t'(1));

    // UDIS: counter still wraps and UG still resets it, but no UEV and shadows hold.
    r_cc_pre = wide_t'(16'h0AAA);
    r_ug     = 1'b1;
    step();
    r_ug     = 1'b0;
    r_udis   = 1'b1;
    r_cc_pre = wide_t'(16'h0BBB);
    r_arr    = 16'd3;
    step();
    r_ug = 1'b1;
    step();
    r_ug = 1'b0;
    chk("udis_ug_cnt", wide_t'(arr_cnt), wide_t'(0));
    chk("udis_ug_uev", wide_t'(uev), wide_t'(0));
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("udis_cnt", wide_t'(arr_cnt), wide_t'(i % 4));
      chk("udis_uev", wide_t'(uev), wide_t'(0));
    end
    chk("udis_cc_hold", cc_act, wide_t'(16'h0AAA));

    // One-pulse mode: single period, then stopped until CEN toggles.
    r_udis = 1'b0;
    r_cen  = 1'b0;
    step();
    step();
    r_opm = 1'b1; r_arr = 16'd2; r_rcr = '0; r_ug = 1'b1;
    step();
    r_ug  = 1'b0;
    r_cen = 1'b1;
    step();
    chk("opm_te_on", wide_t'(timing_enable), wide_t'(1));
    step();
    chk("opm_cnt1", wide_t'(arr_cnt), wide_t'(1));
    step();
    chk("opm_cnt2", wide_t'(arr_cnt), wide_t'(2));
    step();
    chk("opm_wrap_cnt", wide_t'(arr_cnt), wide_t'(0));
    chk("opm_wrap_uev", wide_t'(uev), wide_t'(1));
    chk("opm_te_off", wide_t'(timing_enable), wide_t'(0));
    chk("opm_cenclr", wide_t'(cen_clr), wide_t'(1));
    step();
    chk("opm_cenclr_once", wide_t'(cen_clr), wide_t'(0));
    step();
    step();
    chk("opm_stay_te", wide_t'(timing_enable), wide_t'(0));
    chk("opm_stay_cnt", wide_t'(arr_cnt), wide_t'(0));
    r_cen = 1'b0;
    step();
    r_cen = 1'b1;
    step();
    chk("opm_restart", wide_t'(timing_enable), wide_t'(1));
    step();
    chk("opm_run_cnt", wide_t'(arr_cnt), wide_t'(1));

    // Asynchronous reset mid-count clears outputs without waiting for a clock edge.
    pe_gen_rstn = 1'b0;
    #1;
    chk_all_zero("arst");
    #2;
    pe_gen_rstn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
